decoder_seq: RTL and testbench

- Handshaked, state-machine-driven successor to the single-cycle instruction decoder.
- Accepts opcodes from fetch through a valid/ready handshake and issues registered ALU-op and control-flag words to the datapath through a second valid/ready handshake.
- Reports halt and illegal-instruction conditions as sticky status outputs instead of ending simulation.
- Counts retired instructions.
- Parametrised in opcode, ALU-op, flag and counter widths.

---
 rtl/decoder_pkg.sv | 32 +++
 rtl/decoder_rom.sv | 61 ++++++
 rtl/decoder_seq.sv | 99 +++++++++
 tb/tb_decoder_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared opcode, control-flag, ALU-op and state definitions for the decoder
package decoder_pkg;

  localparam int OPC_W  = 3;
  localparam int FBASE_W = 6;

  localparam logic [OPC_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OPC_W-1:0] OP_HALT = 3'd1;
  localparam logic [OPC_W-1:0] OP_SET  = 3'd2;
  localparam logic [OPC_W-1:0] OP_COPY = 3'd3;
  localparam logic [OPC_W-1:0] OP_ADDR = 3'd4;
  localparam logic [OPC_W-1:0] OP_ADDV = 3'd5;
  localparam logic [OPC_W-1:0] OP_SUBR = 3'd6;
  localparam logic [OPC_W-1:0] OP_SUBV = 3'd7;

  // Written with flag index 0 as the leftmost character
  localparam logic [FBASE_W-1:0] FLAGS_SET   = 6'b010100;
  localparam logic [FBASE_W-1:0] FLAGS_COPY  = 6'b100110;
  localparam logic [FBASE_W-1:0] FLAGS_ALU_R = 6'b111111;
  localparam logic [FBASE_W-1:0] FLAGS_ALU_V = 6'b110110;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HALTED,
    ST_TRAP
  } dec_state_t;

endpackage

// File: rtl/decoder_rom.sv
// rtl/decoder_rom.sv - combinational opcode to control-word lookup
module decoder_rom
  import decoder_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int ALU_OP_W = 1,
  parameter int FLAGS_W  = 6
) (
  input  logic [OP_W-1:0]     op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_op_we,
  output logic [0:FLAGS_W-1]  flags,
  output logic                is_nop,
  output logic                is_halt,
  output logic                is_illegal
);

  logic op_high;
  assign op_high = (op >> OPC_W) != '0;

  always_comb begin
    alu_op     = '0;
    alu_op_we  = 1'b0;
    flags      = '0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (op_high) begin
      is_illegal = 1'b1;
    end else begin
      case (op[OPC_W-1:0])
        OP_NOP:  is_nop = 1'b1;
        OP_HALT: is_halt = 1'b1;
        OP_SET:  flags[0:FBASE_W-1] = FLAGS_SET;
        OP_COPY: flags[0:FBASE_W-1] = FLAGS_COPY;
        OP_ADDR: begin
          alu_op[0] = ALU_ADD;
          alu_op_we = 1'b1;
          flags[0:FBASE_W-1] = FLAGS_ALU_R;
        end
        OP_ADDV: begin
          alu_op[0] = ALU_ADD;
          alu_op_we = 1'b1;
          flags[0:FBASE_W-1] = FLAGS_ALU_V;
        end
        OP_SUBR: begin
          alu_op[0] = ALU_SUB;
          alu_op_we = 1'b1;
          flags[0:FBASE_W-1] = FLAGS_ALU_R;
        end
        OP_SUBV: begin
          alu_op[0] = ALU_SUB;
          alu_op_we = 1'b1;
          flags[0:FBASE_W-1] = FLAGS_ALU_V;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - handshaked decoder issuing registered ALU-op and control flags
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int ALU_OP_W = 1,
  parameter int FLAGS_W  = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [0:FLAGS_W-1]  flags,
  output logic                ctrl_valid,
  input  logic                ctrl_ready,
  output logic                halted,
  output logic                illegal,
  output logic [OP_W-1:0]     trap_op,
  output logic [CNT_W-1:0]    retired
);

  dec_state_t state;

  logic [ALU_OP_W-1:0] rom_alu_op;
  logic                rom_alu_op_we;
  logic [0:FLAGS_W-1]  rom_flags;
  logic                rom_nop;
  logic                rom_halt;
  logic                rom_illegal;
  logic                accept;

  decoder_rom #(
    .OP_W     (OP_W),
    .ALU_OP_W (ALU_OP_W),
    .FLAGS_W  (FLAGS_W)
  ) u_rom (
    .op         (op),
    .alu_op     (rom_alu_op),
    .alu_op_we  (rom_alu_op_we),
    .flags      (rom_flags),
    .is_nop     (rom_nop),
    .is_halt    (rom_halt),
    .is_illegal (rom_illegal)
  );

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_op     <= '0;
      flags      <= '0;
      ctrl_valid <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      trap_op    <= '0;
      retired    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (rom_illegal) begin
              state   <= ST_TRAP;
              illegal <= 1'b1;
              trap_op <= op;
            end else if (rom_halt) begin
              state   <= ST_HALTED;
              halted  <= 1'b1;
              retired <= retired + CNT_W'(1);
            end else if (rom_nop) begin
              retired <= retired + CNT_W'(1);
            end else begin
              // set/copy leave the previous ALU op in place
              state      <= ST_ISSUE;
              flags      <= rom_flags;
              ctrl_valid <= 1'b1;
              if (rom_alu_op_we) alu_op <= rom_alu_op;
            end
          end
        end
        ST_ISSUE: begin
          if (ctrl_ready) begin
            state      <= ST_IDLE;
            ctrl_valid <= 1'b0;
            retired    <= retired + CNT_W'(1);
          end
        end
        ST_HALTED: ;
        ST_TRAP:   ;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - self-checking bench for decoder_seq with a behavioural reference model
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       reset, op_valid, ctrl_ready;
  logic [2:0] op;
  logic       op_ready, ctrl_valid, halted, illegal;
  logic [0:0] alu_op;
  logic [0:5] flags;
  logic [2:0] trap_op;
  logic [15:0] retired;

  logic       reset2, op_valid2, ctrl_ready2;
  logic [3:0] op2;
  logic       op_ready2, ctrl_valid2, halted2, illegal2;
  logic [0:0] alu_op2;
  logic [0:5] flags2;
  logic [3:0] trap_op2;
  logic [1:0] retired2;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  decoder_seq u_dut (
    .clock(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .alu_op(alu_op), .flags(flags), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .halted(halted), .illegal(illegal), .trap_op(trap_op), .retired(retired)
  );

  decoder_seq #(.OP_W(4), .CNT_W(2)) u_dut2 (
    .clock(clk), .reset(reset2), .op(op2), .op_valid(op_valid2), .op_ready(op_ready2),
    .alu_op(alu_op2), .flags(flags2), .ctrl_valid(ctrl_valid2), .ctrl_ready(ctrl_ready2),
    .halted(halted2), .illegal(illegal2), .trap_op(trap_op2), .retired(retired2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: opcode tables plus a pending/terminal view of the decoder
  int flag_tbl[8] = '{0, 0, 'b010100, 'b100110, 'b111111, 'b110110, 'b111111, 'b110110};
  int alu_tbl[8]  = '{-1, -1, -1, -1, 0, 0, 1, 1};
  bit m_pending = 0, m_halt = 0, m_ill = 0;
  int m_ret = 0, m_flags = 0, m_alu = 0, m_trap = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 0; m_halt = 0; m_ill = 0;
      m_ret = 0; m_flags = 0; m_alu = 0; m_trap = 0;
    end else if (m_halt || m_ill) begin
    end else if (m_pending) begin
      if (ctrl_ready) begin
        m_pending = 0;
        m_ret = (m_ret + 1) % 65536;
      end
    end else if (op_valid) begin
      if (op == 0) m_ret = (m_ret + 1) % 65536;
      else if (op == 1) begin
        m_halt = 1;
        m_ret = (m_ret + 1) % 65536;
      end else begin
        m_pending = 1;
        m_flags = flag_tbl[op];
        if (alu_tbl[op] >= 0) m_alu = alu_tbl[op];
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("op_ready",   32'(op_ready),   32'(!m_pending && !m_halt && !m_ill));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(m_pending));
      chk("flags",      32'(flags),      m_flags);
      chk("alu_op",     32'(alu_op),     m_alu);
      chk("halted",     32'(halted),     32'(m_halt));
      chk("illegal",    32'(illegal),    32'(m_ill));
      chk("trap_op",    32'(trap_op),    m_trap);
      chk("retired",    32'(retired),    m_ret);
    end
  end

  task automatic do_reset();
    reset = 1'b1; op_valid = 1'b0; ctrl_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int seq_op[5] = '{5, 6, 2, 3, 7};
  int seq_f[5]  = '{'b110110, 'b111111, 'b010100, 'b100110, 'b110110};
  int seq_a[5]  = '{0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1; op = '0; op_valid = 1'b0; ctrl_ready = 1'b0;
    reset2 = 1'b1; op2 = '0; op_valid2 = 1'b0; ctrl_ready2 = 1'b0;
    @(negedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_flags", 32'(flags), 0);
    reset = 1'b0;

    // addr held while the datapath stalls for three cycles
    op = 3'd4; op_valid = 1'b1; ctrl_ready = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("t1_valid", 32'(ctrl_valid), 1);
    chk("t1_flags", 32'(flags), 'b111111);
    repeat (2) @(negedge clk);
    chk("t1_hold", 32'(ctrl_valid), 1);
    ctrl_ready = 1'b1;
    @(negedge clk);
    ctrl_ready = 1'b0;
    chk("t1_drop", 32'(ctrl_valid), 0);
    chk("t1_retired", 32'(retired), 1);
    chk("t1_ready", 32'(op_ready), 1);
    chk("t1_alu", 32'(alu_op), 0);

    // back-to-back issues with an always-ready datapath
    do_reset();
    ctrl_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = 3'(seq_op[i]); op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      chk("t2_flags", 32'(flags), seq_f[i]);
      chk("t2_alu", 32'(alu_op), seq_a[i]);
      @(negedge clk);
      chk("t2_idle", 32'(op_ready), 1);
    end
    ctrl_ready = 1'b0;
    chk("t2_retired", 32'(retired), 5);

    // nops retire one per cycle
    do_reset();
    op = 3'd0; op_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t3_retired", 32'(retired), i);
      chk("t3_ready", 32'(op_ready), 1);
      chk("t3_valid", 32'(ctrl_valid), 0);
    end
    op_valid = 1'b0;

    // halt is terminal; a following op is never accepted
    do_reset();
    op = 3'd1; op_valid = 1'b1;
    @(negedge clk);
    op = 3'd4;
    repeat (3) @(negedge clk);
    chk("t4_halted", 32'(halted), 1);
    chk("t4_ready", 32'(op_ready), 0);
    chk("t4_valid", 32'(ctrl_valid), 0);
    chk("t4_retired", 32'(retired), 1);
    chk("t4_illegal", 32'(illegal), 0);
    op_valid = 1'b0;
    do_reset();
    chk("t4_rst_halted", 32'(halted), 0);
    chk("t4_rst_retired", 32'(retired), 0);

    // reset while an issue is stalled
    op = 3'd6; op_valid = 1'b1; ctrl_ready = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("t5_valid", 32'(ctrl_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_valid_rst", 32'(ctrl_valid), 0);
    chk("t5_flags_rst", 32'(flags), 0);
    chk("t5_ready_rst", 32'(op_ready), 1);
    @(negedge clk);

    // wide-opcode, narrow-counter instance: wrap then trap
    reset2 = 1'b0;
    op2 = 4'd0; op_valid2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_wrap", 32'(retired2), 1);
    op2 = 4'd9;
    @(negedge clk);
    op_valid2 = 1'b0;
    chk("t6_illegal", 32'(illegal2), 1);
    chk("t6_trap_op", 32'(trap_op2), 9);
    chk("t6_retired", 32'(retired2), 1);
    chk("t6_ready", 32'(op_ready2), 0);
    chk("t6_halted", 32'(halted2), 0);
    op2 = 4'd4; op_valid2 = 1'b1;
    @(negedge clk);
    chk("t6_stuck", 32'(ctrl_valid2), 0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
